// File: rtl/sdspi_perf_monitor.sv
// sdspi_perf_monitor
//   Measures one SD SPI transaction for the autotest sequencer: cycles from
//   start until the unit under test raises finish, SPI clock rising edges and
//   chip-select assertions seen during that window. A run that exceeds
//   TIMEOUT_CYCLES is aborted into TOUT. Results stay frozen until next start.
//
//   Optional build macro: SDSPI_PERF_MON_SYNC_EN -- adds 2-flop synchronizers
//   on sclk/cs ahead of edge detection (2 cycles extra edge latency).
//
// Ports
//   clk      : system clock
//   rst      : synchronous active-high reset
//   start    : one-cycle pulse, arms a measurement (ignored while running)
//   finish   : level completion flag from the unit under test
//   sclk, cs : UUT SPI clock and active-low chip select
//   sel[1:0] : debug word select (0 elapsed, 1 sclk edges, 2 cs asserts, 3 status)
//   busy     : running
//   done     : finished normally
//   timeout  : aborted on cycle limit
//   debug    : selected result word, registered (1-cycle latency from sel)
module sdspi_perf_monitor #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        finish,
  input  logic        sclk,
  input  logic        cs,
  input  logic [1:0]  sel,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] debug
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TOUT} state_t;

  state_t      r_state, w_next;
  logic        w_clear, w_inc_el;
  logic [31:0] r_elapsed, r_sclk_cnt, r_cs_cnt, r_debug;
  logic        r_sclk_q, r_cs_q;
  logic        w_sclk, w_cs, w_sclk_rise, w_cs_fall, w_sync_en;

`ifdef SDSPI_PERF_MON_SYNC_EN
  logic [1:0] r_sclk_sync, r_cs_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_cs_sync   <= {r_cs_sync[0], cs};
    end
  end

  assign w_sclk    = r_sclk_sync[1];
  assign w_cs      = r_cs_sync[1];
  assign w_sync_en = 1'b1;
`else
  assign w_sclk    = sclk;
  assign w_cs      = cs;
  assign w_sync_en = 1'b0;
`endif

  // Edge history runs in every state so the first RUN cycle never sees a
  // stale level as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_q <= 1'b0;
      r_cs_q   <= 1'b1;
    end else begin
      r_sclk_q <= w_sclk;
      r_cs_q   <= w_cs;
    end
  end

  assign w_sclk_rise = w_sclk & ~r_sclk_q;
  assign w_cs_fall   = ~w_cs & r_cs_q;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Finish is checked before the limit so a simultaneous finish wins.
  always_comb begin
    w_next   = r_state;
    w_clear  = 1'b0;
    w_inc_el = 1'b0;
    case (r_state)
      S_RUN: begin
        if (finish)                           w_next = S_DONE;
        else if (r_elapsed == TIMEOUT_CYCLES) w_next = S_TOUT;
        else                                  w_inc_el = 1'b1;
      end
      default: begin
        if (start) begin
          w_next  = S_RUN;
          w_clear = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_elapsed  <= '0;
      r_sclk_cnt <= '0;
      r_cs_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      if (w_inc_el && r_elapsed != CNT_MAX)     r_elapsed  <= r_elapsed + 32'd1;
      if (w_sclk_rise && r_sclk_cnt != CNT_MAX) r_sclk_cnt <= r_sclk_cnt + 32'd1;
      if (w_cs_fall && r_cs_cnt != CNT_MAX)     r_cs_cnt   <= r_cs_cnt + 32'd1;
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign timeout = (r_state == S_TOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_debug <= '0;
    end else begin
      case (sel)
        2'd0:    r_debug <= r_elapsed;
        2'd1:    r_debug <= r_sclk_cnt;
        2'd2:    r_debug <= r_cs_cnt;
        default: r_debug <= {28'h0, timeout, done, busy, w_sync_en};
      endcase
    end
  end

  assign debug = r_debug;

endmodule

// File: tb/tb_sdspi_perf_monitor.sv
module tb_sdspi_perf_monitor;

`ifdef SDSPI_PERF_MON_SYNC_EN
  localparam bit SE = 1'b1;
  localparam int LAT = 2;
`else
  localparam bit SE = 1'b0;
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, finish = 1'b0, sclk = 1'b0, cs = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic        busy_a, done_a, tout_a, busy_b, done_b, tout_b;
  logic [31:0] debug_a, debug_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Instance A: default (effectively unreachable) limit. Instance B: 50 cycles.
  sdspi_perf_monitor dut_a (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .sclk(sclk), .cs(cs),
    .sel(sel), .busy(busy_a), .done(done_a), .timeout(tout_a), .debug(debug_a));

  sdspi_perf_monitor #(.TIMEOUT_CYCLES(32'd50)) dut_b (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .sclk(sclk), .cs(cs),
    .sel(sel), .busy(busy_b), .done(done_b), .timeout(tout_b), .debug(debug_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Read a result word: sel is registered, so it appears after one edge.
  task automatic rd_a(input logic [1:0] s, input string name, input logic [31:0] exp);
    sel = s;
    tick();
    chk(name, debug_a, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; finish = 1'b0; sclk = 1'b0; cs = 1'b1; sel = 2'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        rst, start, finish;
    logic [1:0]  sel;
    logic        busy, done, tout;
    logic [31:0] debug;
  } vec_t;

  function automatic vec_t mk(logic r, logic st, logic f, logic [1:0] s,
                              logic b, logic d, logic t, logic [31:0] dbg);
    vec_t v;
    v.rst = r; v.start = st; v.finish = f; v.sel = s;
    v.busy = b; v.done = d; v.tout = t; v.debug = dbg;
    return v;
  endfunction

  vec_t tbl[11];

  // ---------------- behavioural reference ----------------
  // One record per instance: mode 0 idle, 1 run, 2 done, 3 timed out.
  typedef struct {
    int          mode;
    longint      el, sc, cc;
    logic        last_s, last_c;
    logic [31:0] dbg;
  } mdl_t;

  mdl_t        m[2];
  longint      lim[2];
  logic        hs[$], hc[$];   // raw pin history for the synchronizer delay
  localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

  function automatic longint sat(longint v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].mode = 0; m[k].el = 0; m[k].sc = 0; m[k].cc = 0;
      m[k].last_s = 1'b0; m[k].last_c = 1'b1; m[k].dbg = '0;
    end
    hs.delete(); hc.delete();
    for (int k = 0; k < LAT; k++) begin hs.push_back(1'b0); hc.push_back(1'b1); end
  endtask

  // Advance the model across one clock edge with the current pin values.
  task automatic mdl_step();
    logic es, ec;
    if (rst) begin
      mdl_reset();
      return;
    end
    hs.push_back(sclk); hc.push_back(cs);
    es = hs.pop_front(); ec = hc.pop_front();
    for (int k = 0; k < 2; k++) begin
      case (sel)
        2'd0: m[k].dbg = m[k].el[31:0];
        2'd1: m[k].dbg = m[k].sc[31:0];
        2'd2: m[k].dbg = m[k].cc[31:0];
        default: m[k].dbg = {28'h0, m[k].mode == 3, m[k].mode == 2, m[k].mode == 1, SE};
      endcase
      if (m[k].mode == 1) begin
        if (es && !m[k].last_s)  m[k].sc = sat(m[k].sc);
        if (!ec && m[k].last_c)  m[k].cc = sat(m[k].cc);
        if (finish)              m[k].mode = 2;
        else if (m[k].el == lim[k]) m[k].mode = 3;
        else                     m[k].el = sat(m[k].el);
      end else if (start) begin
        m[k].mode = 1; m[k].el = 0; m[k].sc = 0; m[k].cc = 0;
      end
      m[k].last_s = es; m[k].last_c = ec;
    end
  endtask

  initial begin
    lim[0] = 64'd100_000_000;
    lim[1] = 64'd50;

    //              rst st fin sel  busy done tout debug
    tbl[0]  = mk(1, 0, 0, 2'd0, 0, 0, 0, 32'd0);
    tbl[1]  = mk(0, 1, 0, 2'd0, 1, 0, 0, 32'd0);
    tbl[2]  = mk(0, 0, 0, 2'd0, 1, 0, 0, 32'd0);
    tbl[3]  = mk(0, 0, 0, 2'd0, 1, 0, 0, 32'd1);
    tbl[4]  = mk(0, 0, 1, 2'd0, 0, 1, 0, 32'd2);
    tbl[5]  = mk(0, 0, 1, 2'd3, 0, 1, 0, {28'h0, 3'b010, SE});
    tbl[6]  = mk(0, 0, 0, 2'd0, 0, 1, 0, 32'd2);
    tbl[7]  = mk(0, 1, 0, 2'd0, 1, 0, 0, 32'd2);
    tbl[8]  = mk(0, 0, 0, 2'd0, 1, 0, 0, 32'd0);
    tbl[9]  = mk(1, 0, 0, 2'd0, 0, 0, 0, 32'd0);
    tbl[10] = mk(0, 0, 0, 2'd3, 0, 0, 0, {31'h0, SE});

    #2;
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; finish = tbl[i].finish; sel = tbl[i].sel;
      tick();
      chk($sformatf("tbl%0d.status", i), {29'h0, tout_a, done_a, busy_a},
          {29'h0, tbl[i].tout, tbl[i].done, tbl[i].busy});
      chk($sformatf("tbl%0d.debug", i), debug_a, tbl[i].debug);
    end

    // 100 RUN cycles then finish -> elapsed 100
    do_reset();
    pulse_start();
    repeat (100) tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("run100.done", {31'h0, done_a}, 32'd1);
    rd_a(2'd0, "run100.elapsed", 32'd100);

    // 8 sclk pulses (2 high / 2 low) and 3 cs low pulses
    do_reset();
    pulse_start();
    for (int p = 0; p < 8; p++) begin
      sclk = 1'b1; cs = (p % 2 == 1 && p < 6) ? 1'b0 : 1'b1;
      repeat (2) tick();
      sclk = 1'b0; cs = 1'b1;
      repeat (2) tick();
    end
    repeat (4) tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("edges.done", {31'h0, done_a}, 32'd1);
    rd_a(2'd1, "edges.sclk", 32'd8);
    rd_a(2'd2, "edges.cs", 32'd3);

    // limit 50 reached with finish low -> TOUT, results frozen
    do_reset();
    pulse_start();
    repeat (50) tick();
    chk("tout.busy_before", {31'h0, busy_b}, 32'd1);
    tick();
    chk("tout.flags", {29'h0, tout_b, done_b, busy_b}, 32'd4);
    repeat (3) begin sclk = 1'b1; tick(); sclk = 1'b0; tick(); end
    sel = 2'd0; tick();
    chk("tout.elapsed", debug_b, 32'd50);
    sel = 2'd1; tick();
    chk("tout.sclk_frozen", debug_b, 32'd0);

    // finish arrives in the same cycle the limit is hit -> DONE wins
    do_reset();
    pulse_start();
    repeat (50) tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("tie.flags", {29'h0, tout_b, done_b, busy_b}, 32'd2);
    sel = 2'd0; tick();
    chk("tie.elapsed", debug_b, 32'd50);

    // reset mid-RUN at elapsed 20, then a fresh run counts from zero
    do_reset();
    pulse_start();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.status", {29'h0, tout_a, done_a, busy_a}, 32'd0);
    chk("midrst.debug", debug_a, 32'd0);
    pulse_start();
    repeat (5) tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    rd_a(2'd0, "midrst.rerun", 32'd5);

    // start during RUN is ignored; start in DONE re-arms and clears
    do_reset();
    pulse_start();
    repeat (10) tick();
    pulse_start();
    repeat (4) tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    rd_a(2'd0, "restart.run_ignored", 32'd15);
    pulse_start();
    chk("restart.busy", {31'h0, busy_a}, 32'd1);
    tick();
    chk("restart.cleared", debug_a, 32'd0);

    // randomized traffic against the reference model, both instances
    rst = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) begin
        rst    = ($urandom_range(0, 299) == 0);
        start  = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 19) == 0) finish = ~finish;
        if ($urandom_range(0, 2) == 0)  sclk = ~sclk;
        if ($urandom_range(0, 6) == 0)  cs = ~cs;
        sel    = 2'($urandom_range(0, 3));
      end
      mdl_step();
      tick();
      chk($sformatf("rnd%0d.a", c), {tout_a, done_a, busy_a, debug_a[28:0]},
          {m[0].mode == 3, m[0].mode == 2, m[0].mode == 1, m[0].dbg[28:0]});
      chk($sformatf("rnd%0d.b", c), {tout_b, done_b, busy_b, debug_b[28:0]},
          {m[1].mode == 3, m[1].mode == 2, m[1].mode == 1, m[1].dbg[28:0]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sdspi_perf_monitor.md
SDSPI_PERF_MONITOR -- requirements
Module: sdspi_perf_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd100_000_000, RUN-state cycle limit before abort.
REQ-002 SHALL have port clk, input, 1, system clock; the only clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle pulse from the autotest sequencer that arms a measurement.
REQ-005 SHALL have port finish, input, 1, level completion flag from the SD SPI unit under test.
REQ-006 SHALL have port sclk, input, 1, UUT SPI clock.
REQ-007 SHALL have port cs, input, 1, UUT SPI chip select, active low.
REQ-008 SHALL have port sel, input, 2, debug word select.
REQ-009 SHALL have port busy, output, 1, high in RUN.
REQ-010 SHALL have port done, output, 1, high in DONE.
REQ-011 SHALL have port timeout, output, 1, high in TOUT.
REQ-012 SHALL have port debug, output, 32, selected result word for the 7-segment display.

Function
REQ-013 SHALL implement FSM IDLE, RUN, DONE, TOUT.
REQ-014 SHALL go IDLE/DONE/TOUT -> RUN on start=1, clearing all three counters in that transition cycle.
REQ-015 SHALL ignore start while in RUN.
REQ-016 SHALL go RUN -> DONE when finish is sampled 1, with no elapsed increment in that cycle.
REQ-017 SHALL go RUN -> TOUT when elapsed equals TIMEOUT_CYCLES and finish=0.
REQ-018 SHALL give finish priority over timeout when both occur in the same cycle.
REQ-019 SHALL increment elapsed (32 bit) by 1 in every RUN cycle in which finish=0, so entering RUN with finish already 1 yields elapsed=0.
REQ-020 SHALL detect sclk rising edges as sclk & ~sclk_q and count them (32 bit) only in RUN.
REQ-021 SHALL detect cs falling edges as ~cs & cs_q and count them (32 bit) only in RUN.
REQ-022 SHALL update sclk_q and cs_q every cycle in all states, so no spurious edge is counted on RUN entry.
REQ-023 SHALL saturate all counters at 32'hFFFF_FFFF and never wrap.
REQ-024 SHALL freeze all counters in DONE and TOUT until the next start.
REQ-025 SHALL drive debug as a registered output with 1-cycle latency from sel.
REQ-026 SHALL map sel to debug: 0 = elapsed; 1 = sclk edges; 2 = cs assertions; 3 = {28'h0, timeout, done, busy, sync_en}.
REQ-027 SHALL decode busy, done and timeout directly from the state register, one-hot, with none of them asserted in IDLE.

Reset
REQ-028 SHALL on rst=1 at a clk edge set state=IDLE, all counters=0, sclk_q=0, cs_q=1, debug=0, busy=done=timeout=0.
REQ-029 SHALL give rst priority over start and finish, including when rst occurs mid-RUN, and discard any partial measurement.

Configuration
REQ-030 SHALL, when SDSPI_PERF_MON_SYNC_EN is defined, pass sclk and cs through 2-flop synchronizers (reset sclk=0, cs=1) ahead of edge detection, adding 2 cycles of edge-count latency, and report sync_en=1.
REQ-031 SHALL, when SDSPI_PERF_MON_SYNC_EN is undefined, feed sclk and cs straight to the edge detectors and report sync_en=0.
REQ-032 SHALL accept that, with SDSPI_PERF_MON_SYNC_EN defined, edges occurring in the 2 cycles before finish are excluded from the counts.

Verification
REQ-033 SHALL cover: start pulse, finish rises after 100 RUN cycles -> done=1, sel=0 gives debug=100.
REQ-034 SHALL cover: in RUN, 8 sclk pulses (high 2 cycles, low 2 cycles) and 3 cs low pulses, then finish -> sel=1 gives 8, sel=2 gives 3.
REQ-035 SHALL cover: TIMEOUT_CYCLES=50 and finish held 0 -> timeout=1, elapsed=50, counters frozen.
REQ-036 SHALL cover: finish=1 in the same cycle elapsed reaches TIMEOUT_CYCLES -> done=1, timeout=0.
REQ-037 SHALL cover: rst mid-RUN at elapsed=20 -> next cycle state IDLE, debug=0; a new start then counts from 0.
REQ-038 SHALL cover: start pulse in RUN -> counters not cleared; start in DONE -> counters cleared, busy=1.
